rv_mem_resp: RTL
================

Name: rv_mem_resp

Overview:
- Memory-side responder for the multicycle RISC-V core: the target end of the core's instruction/data memory port.
- Accepts one request at a time over a req/ack handshake and inserts a fixed number of wait states.
- Performs a word read or a byte-enabled write on an internal synchronous RAM, then returns a one-cycle ack with read data or an error flag.
- Sits between the core's memory port and nothing else. Single-port, no pipelining of requests.

Parameters:
- ADDR_W, 10: word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- WAIT_CYC, 2: wait states inserted before the access; legal range 0..15.
- ERR_DATA, 32'hDEAD_BEEF: value driven on rdata for an errored read.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  write data; sampled with req.
- be  in  4  byte enables for writes, be[i] selects wdata[8i+7:8i]; ignored for reads.
- rdata  out  32  read data, registered; holds its value until the next read completes.
- ack  out  1  one-cycle pulse; transaction complete.
- err  out  1  valid only with ack; transaction rejected.
- busy  out  1  high from the accept edge until the cycle after ack.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; ack = 0, err = 0, busy = 0, rdata = 32'h0, wait counter = 0.
  - RAM contents are not reset.
  - Reset during WAIT aborts the transaction: no RAM write occurs and no ack is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1, latch we, addr, wdata, be. Set busy=1.
  - Load the counter with WAIT_CYC.
  - Next state is WAIT if WAIT_CYC > 0; otherwise next state is RESP, with the access performed on this same edge.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter equals 1, perform the access and go to RESP.
- Access (single edge):
  - Error if addr[1:0] != 0 (misaligned) or addr[31:ADDR_W+2] != 0 (out of range).
  - On error: no RAM write; rdata <= ERR_DATA for reads; rdata unchanged for writes; err_q <= 1.
  - Read without error: rdata <= RAM[addr[ADDR_W+1:2]].
  - Write without error: only bytes with be[i]=1 are updated; rdata unchanged.
  - be = 4'b0000 on a write is legal and completes with no RAM change and err = 0.
- RESP:
  - ack = 1 and err = err_q for exactly this cycle. Next state is IDLE; busy drops on that edge.
  - A req seen in RESP is ignored. A new request is accepted only in IDLE.
- Latency: ack is high in cycle N+WAIT_CYC+1, where N is the accept cycle. Minimum spacing between accepts is WAIT_CYC+2 cycles.
- Input changes after the accept edge have no effect on the transaction in flight.
- The requester may hold req high continuously; it is then re-accepted each time the block reaches IDLE.

Optional Feature:
- Macro: RV_MEM_STATS_EN.
- Defined:
  - Adds output ports rd_cnt[15:0], wr_cnt[15:0], err_cnt[15:0].
  - Each counter increments on the access edge of a successful read, a successful write, or an errored transaction, respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: after rst=0 pulse → ack=0, err=0, busy=0, rdata=0; no ack for 20 cycles with req=0.
- Write/read, WAIT_CYC=2: write addr=0x10, wdata=0x12345678, be=4'hF accepted cycle 0 → ack in cycle 3, err=0. Read of 0x10 accepted cycle 5 → ack in cycle 8 with rdata=0x12345678.
- Byte enables: memory at 0x10 = 0x12345678; write wdata=0xAABBCCDD, be=4'b0101 → read returns 0x12BB56DD.
- Errors:
  - Read addr=0x11 → ack with err=1, rdata=0xDEADBEEF.
  - Write addr=0x1000 with ADDR_W=10 → ack with err=1, and a following read of 0x0 is unchanged.
- Back-to-back and ignore: req held high for 10 cycles with WAIT_CYC=2 → accepts in cycles 0 and 4, acks in cycles 3 and 7. Inputs changed during WAIT do not alter the result.
- Mid-operation reset: write 0x5555AAAA to 0x20 with rst asserted during WAIT → no ack; after reset, a read of 0x20 returns the prior contents. With RV_MEM_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/rv_mem_resp.sv
// Memory-side responder: one request at a time, WAIT_CYC wait states, then a one-cycle ack.
// Optional access statistics counters are enabled by defining RV_MEM_STATS_EN.
module rv_mem_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
`ifdef RV_MEM_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, access;

  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic        err_q;

  logic        a_we;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        addr_err;
  logic [ADDR_W-1:0] a_idx;
  logic        mem_wr;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_d  = WAIT_LD;
          if (WAIT_CYC == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so operands
  // come straight from the ports; otherwise from the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_we    = we;
      a_addr  = addr;
      a_wdata = wdata;
      a_be    = be;
    end else begin
      a_we    = lat_we;
      a_addr  = lat_addr;
      a_wdata = lat_wdata;
      a_be    = lat_be;
    end
  end

  assign addr_err = (a_addr[1:0] != 2'b00) || ((a_addr >> (ADDR_W + 2)) != 32'd0);
  assign a_idx    = a_addr[ADDR_W+1:2];
  assign mem_wr   = rst && access && a_we && !addr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      err_q     <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
      if (access) begin
        err_q <= addr_err;
        if (!a_we) begin
          rdata <= addr_err ? ERR_DATA : mem[a_idx];
        end
      end
    end
  end

  // RAM contents survive reset; mem_wr is gated by rst so an abort never writes.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ack  = (state_q == S_RESP);
  assign err  = ack && err_q;
  assign busy = (state_q != S_IDLE);

`ifdef RV_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (access) begin
      if (addr_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      end else if (a_we) begin
        if (wr_cnt != '1) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != '1) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
